vga_timing_rx: RTL and testbench

Sink-side VGA timing receiver that consumes active-low hsync, active-low vsync and draw-enable from a 640x480-class timing source. It measures line and frame periods, declares lock after repeated identical frames, and recovers active-area pixel coordinates for downstream capture and checking logic. All inputs are synchronous to i_VGA_CLOCK; no CDC is performed in this block.

---
 rtl/vga_timing_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame periods of an incoming
// hsync/vsync/de stream, declares lock after repeated identical frames and
// recovers active-area pixel coordinates with one clock of latency.
module vga_timing_rx #(
  parameter int CNT_W       = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             i_VGA_CLOCK,
  input  logic             i_rst,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_de,
  output logic             o_de,
  output logic [9:0]       o_Sx,
  output logic [9:0]       o_Sy,
  output logic             o_frame_start,
  output logic             o_locked,
  output logic             o_lock_lost,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_v_total
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  // Counter increment that sticks at all-ones; the stuck value doubles as timeout.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t           state, state_n;
  logic             prev_hsync, prev_vsync;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_last;
  logic             h_last_vld;
  logic             h_stable;
  logic [CNT_W-1:0] ref_h, ref_v;
  logic             ref_vld;
  logic [3:0]       match_cnt;
  logic [9:0]       x_cnt, y_cnt;

  logic             hs_edge, vs_edge, de_fall;
  logic [CNT_W-1:0] line_per, cur_line;
  logic             line_mis, stable_now, timeout;
  logic             frame_good, lock_reached;
  logic             ref_clr, ref_load, match_inc, lock_set, lock_drop;

  assign hs_edge  = prev_hsync & ~i_hsync;
  assign vs_edge  = prev_vsync & ~i_vsync;
  // o_de is i_de from the previous clock, so it also serves as de history.
  assign de_fall  = o_de & ~i_de;

  // Period of the line that ends on this hs_edge.
  assign line_per = sat_inc(h_cnt);
  // Most recent line period, including one completing in this very cycle.
  assign cur_line = hs_edge ? line_per : h_last;
  assign line_mis = hs_edge & h_last_vld & (line_per != h_last);
  // A mismatch on an hs_edge coincident with vs_edge still spoils the frame.
  assign stable_now = h_stable & ~line_mis;
  assign timeout    = (h_cnt == CNT_MAX) | (v_cnt == CNT_MAX);

  assign frame_good = stable_now & ref_vld & (cur_line == ref_h) & (v_cnt == ref_v);
  // match_cnt counts repeats after the reference frame, so the reference
  // frame itself is one of the identical frames; +1 for the repeat being
  // accepted now.
  assign lock_reached = (int'(match_cnt) + 2) >= LOCK_FRAMES;

  // Sync history for falling-edge detection; deasserted after reset.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      prev_hsync <= 1'b1;
      prev_vsync <= 1'b1;
    end else begin
      prev_hsync <= i_hsync;
      prev_vsync <= i_vsync;
    end
  end

  // Clocks-in-line and lines-in-frame counters; vsync reload wins over the line count.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= hs_edge ? '0 : sat_inc(h_cnt);
      if (vs_edge) begin
        v_cnt <= hs_edge ? CNT_ONE : '0;
      end else if (hs_edge) begin
        v_cnt <= sat_inc(v_cnt);
      end
    end
  end

  // Track previous line period and whether all lines of this frame matched.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      h_last     <= '0;
      h_last_vld <= 1'b0;
      h_stable   <= 1'b0;
    end else begin
      if (hs_edge) begin
        h_last     <= line_per;
        h_last_vld <= 1'b1;
      end
      if (vs_edge) begin
        h_stable <= 1'b1;
      end else if (line_mis) begin
        h_stable <= 1'b0;
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      state <= SEARCH;
    end else begin
      state <= state_n;
    end
  end

  // Lock FSM next state and per-cycle control strobes.
  always_comb begin
    state_n   = state;
    ref_clr   = 1'b0;
    ref_load  = 1'b0;
    match_inc = 1'b0;
    lock_set  = 1'b0;
    lock_drop = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_n = MEASURE;
          ref_clr = 1'b1;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_n = SEARCH;
        end else if (vs_edge) begin
          if (frame_good) begin
            match_inc = 1'b1;
            if (lock_reached) begin
              state_n  = LOCKED;
              lock_set = 1'b1;
            end
          end else begin
            ref_load = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (timeout ||
            (hs_edge && (line_per != o_h_total)) ||
            (vs_edge && (v_cnt != o_v_total))) begin
          state_n   = SEARCH;
          lock_drop = 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  // Reference frame, match counting and registered lock/status outputs.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      ref_h         <= '0;
      ref_v         <= '0;
      ref_vld       <= 1'b0;
      match_cnt     <= '0;
      o_locked      <= 1'b0;
      o_lock_lost   <= 1'b0;
      o_h_total     <= '0;
      o_v_total     <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= vs_edge;
      o_lock_lost   <= lock_drop;
      if (ref_clr) begin
        ref_vld   <= 1'b0;
        match_cnt <= '0;
      end else if (ref_load) begin
        ref_h     <= cur_line;
        ref_v     <= v_cnt;
        ref_vld   <= 1'b1;
        match_cnt <= '0;
      end else if (match_inc) begin
        match_cnt <= match_cnt + 4'd1;
      end
      if (lock_set) begin
        o_locked  <= 1'b1;
        o_h_total <= ref_h;
        o_v_total <= ref_v;
      end else if (lock_drop) begin
        o_locked  <= 1'b0;
      end
    end
  end

  // Active-area coordinate recovery, registered alongside delayed draw enable.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
      o_Sx  <= '0;
      o_Sy  <= '0;
      o_de  <= 1'b0;
    end else begin
      x_cnt <= i_de ? x_cnt + 10'd1 : '0;
      if (vs_edge) begin
        y_cnt <= '0;
      end else if (de_fall) begin
        y_cnt <= y_cnt + 10'd1;
      end
      o_Sx <= x_cnt;
      o_Sy <= y_cnt;
      o_de <= i_de;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Testbench for vga_timing_rx using a scaled-down 48x24 timing source
// (32x16 active) so many frames fit in a short run.
module tb_vga_timing_rx;

  localparam int H   = 48;
  localparam int HA  = 32;
  localparam int HS0 = 36;
  localparam int HS1 = 42;
  localparam int V   = 24;
  localparam int VA  = 16;
  localparam int VS0 = 20;
  localparam int VS1 = 22;

  logic        clk = 1'b0;
  logic        i_rst, i_hsync, i_vsync, i_de;
  logic        o_de, o_frame_start, o_locked, o_lock_lost;
  logic [9:0]  o_Sx, o_Sy;
  logic [10:0] o_h_total, o_v_total;

  vga_timing_rx #(.CNT_W(11), .LOCK_FRAMES(2)) dut (
    .i_VGA_CLOCK  (clk),
    .i_rst        (i_rst),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .i_de         (i_de),
    .o_de         (o_de),
    .o_Sx         (o_Sx),
    .o_Sy         (o_Sy),
    .o_frame_start(o_frame_start),
    .o_locked     (o_locked),
    .o_lock_lost  (o_lock_lost),
    .o_h_total    (o_h_total),
    .o_v_total    (o_v_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic de;
    logic fs;
    logic chk;
    int   x;
    int   y;
  } sb_t;

  sb_t  sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_vs     = 0;
  int   rise_at  = -1;
  int   lost_cnt = 0;
  int   lost_before;
  logic prev_locked = 1'b0;
  logic prev_vs_m   = 1'b1;
  logic coord_ok    = 1'b0;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one clock of stimulus, push the expected response, then compare.
  task automatic drive(input logic hs, input logic vs, input logic de,
                       input logic rs, input int x, input int y);
    sb_t e;
    i_hsync = hs;
    i_vsync = vs;
    i_de    = de;
    i_rst   = rs;
    e.rst = rs;
    e.de  = rs ? 1'b0 : de;
    e.fs  = !rs && prev_vs_m && !vs;
    e.chk = !rs && de && coord_ok;
    e.x   = x;
    e.y   = y;
    sb.push_back(e);
    if (rs) begin
      prev_vs_m = 1'b1;
      n_vs      = 0;
      rise_at   = -1;
      coord_ok  = 1'b0;
    end else begin
      if (prev_vs_m && !vs) begin
        n_vs++;
        coord_ok = 1'b1;
      end
      prev_vs_m = vs;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("o_de", int'(o_de), int'(e.de));
    check_val("frame_start", int'(o_frame_start), int'(e.fs));
    if (e.chk) begin
      check_val("o_Sx", int'(o_Sx), e.x);
      check_val("o_Sy", int'(o_Sy), e.y);
    end
    if (e.rst) begin
      check_val("rst_locked", int'(o_locked), 0);
      check_val("rst_lock_lost", int'(o_lock_lost), 0);
      check_val("rst_h_total", int'(o_h_total), 0);
      check_val("rst_v_total", int'(o_v_total), 0);
      check_val("rst_Sx", int'(o_Sx), 0);
      check_val("rst_Sy", int'(o_Sy), 0);
    end else begin
      if (o_lock_lost) begin
        lost_cnt++;
        n_vs    = 0;
        rise_at = -1;
      end
      if (o_locked && !prev_locked) rise_at = n_vs;
    end
    prev_locked = o_locked;
  endtask

  // Whole frames from the top-left corner; optional stretched line,
  // one-cycle reset pulse in the first frame, vsync coincident with hsync.
  task automatic run_frames(input int nf, input int stretch, input int rst_line,
                            input bit coinc);
    for (int f = 0; f < nf; f++) begin
      for (int y = 0; y < V; y++) begin
        int hl;
        hl = (y == stretch) ? H + 1 : H;
        for (int x = 0; x < hl; x++) begin
          logic hs, vs, de, rs;
          de = (x < HA) && (y < VA);
          hs = !((x >= HS0) && (x < HS1));
          if (coinc)
            vs = !(((y > VS0) || (y == VS0 && x >= HS0)) &&
                   ((y < VS1) || (y == VS1 && x < HS0)));
          else
            vs = !((y >= VS0) && (y < VS1));
          rs = (f == 0) && (y == rst_line) && (x == 10);
          drive(hs, vs, de, rs, x, y);
        end
      end
    end
  endtask

  task automatic check_locked(input string tag);
    check_val({tag, "_lock_vs_edge"}, rise_at, 3);
    check_val({tag, "_locked"}, int'(o_locked), 1);
    check_val({tag, "_h_total"}, int'(o_h_total), H);
    check_val({tag, "_v_total"}, int'(o_v_total), V);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_hsync = 1'b1;
    i_vsync = 1'b1;
    i_de    = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    // Stream starts at the frame top, so coordinates are valid immediately.
    coord_ok = 1'b1;

    // Acquisition from reset
    run_frames(4, -1, -1, 1'b0);
    check_locked("acquire");
    check_val("acquire_lost", lost_cnt, 0);

    // One stretched line while locked
    run_frames(1, 5, -1, 1'b0);
    check_val("stretch_lost", lost_cnt, 1);
    check_val("stretch_locked", int'(o_locked), 0);
    check_val("stretch_h_hold", int'(o_h_total), H);
    check_val("stretch_v_hold", int'(o_v_total), V);
    run_frames(3, -1, -1, 1'b0);
    check_locked("relock1");

    // Stalled source: hsync held high until h_cnt saturates
    repeat (2000) drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    check_val("stall_early_locked", int'(o_locked), 1);
    check_val("stall_early_lost", lost_cnt, 1);
    repeat (100) drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    check_val("timeout_locked", int'(o_locked), 0);
    check_val("timeout_lost", lost_cnt, 2);
    check_val("timeout_h_hold", int'(o_h_total), H);
    run_frames(3, -1, -1, 1'b0);
    check_locked("relock2");

    // One-cycle reset mid-frame while locked
    lost_before = lost_cnt;
    run_frames(1, -1, 3, 1'b0);
    run_frames(2, -1, -1, 1'b0);
    check_val("midrst_no_lost", lost_cnt, lost_before);
    check_locked("relock3");

    // vsync falling on the same clock as hsync
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    coord_ok = 1'b1;
    run_frames(4, -1, -1, 1'b1);
    check_locked("coinc");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
